// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin APB master shared by NUM_REQ requesters.
// Define APB_PREADY_EN to add the Pready input and slave wait states.
module apb_master_arbiter #(
   parameter int NUM_REQ = 2,
   parameter logic [3:0] BASE_NIBBLE = 4'h8
) (
   input  logic                    clk,
   input  logic                    Hresetn,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [NUM_REQ-1:0]      req_write,
   input  logic [NUM_REQ*32-1:0]   req_addr,
   input  logic [NUM_REQ*32-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]      gnt,
   output logic [NUM_REQ-1:0]      done,
   output logic                    err,
   output logic [31:0]             rdata,
   output logic [31:0]             Paddr,
   output logic [31:0]             Pwdata,
   output logic                    Pwrite,
   output logic [3:0]              Pselx,
   output logic                    Penable,
   input  logic [31:0]             Prdata
`ifdef APB_PREADY_EN
   ,
   input  logic                    Pready
`endif
);
   localparam int IW = $clog2(NUM_REQ);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} state_t;
   state_t state;
   logic [IW-1:0] rr, win, next_rr;
   logic [NUM_REQ-1:0] own, elig;
   logic [31:0] win_addr, win_wdata;
   logic found, legal, ack, fin;
`ifdef APB_PREADY_EN
   assign ack = Pready;
`else
   assign ack = 1'b1;
`endif
   assign fin = (state == ACCESS) && ack;
   // The owner is excluded on its completion edge and while its done pulse is up.
   assign elig = req & ~(done | ((state == ACCESS) ? own : '0));
   always_comb begin
      found = 1'b0;
      win = '0;
      for (int k = 0; k < NUM_REQ; k++)
         if (!found && elig[(int'(rr) + k) % NUM_REQ]) begin
            found = 1'b1;
            win = IW'((int'(rr) + k) % NUM_REQ);
         end
   end
   assign win_addr = req_addr[32*win +: 32];
   assign win_wdata = req_wdata[32*win +: 32];
   assign legal = win_addr[31:28] == BASE_NIBBLE;
   assign next_rr = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
   always_ff @(posedge clk or negedge Hresetn) begin
      if (!Hresetn) begin
         state <= IDLE;
         rr <= '0;
         own <= '0;
         gnt <= '0;
         done <= '0;
         err <= 1'b0;
         rdata <= '0;
         Paddr <= '0;
         Pwdata <= '0;
         Pwrite <= 1'b0;
         Pselx <= '0;
         Penable <= 1'b0;
      end else begin
         gnt <= '0;
         done <= '0;
         err <= 1'b0;
         if (fin) begin
            done <= own;
            if (!Pwrite) rdata <= Prdata;
         end
         if ((state == IDLE || fin) && found) begin
            gnt <= NUM_REQ'(1) << win;
            own <= NUM_REQ'(1) << win;
            rr <= next_rr;
            Penable <= 1'b0;
            Pselx <= legal ? 4'b1 << win_addr[27:26] : 4'b0;
            state <= legal ? SETUP : ERR;
            if (legal) begin
               Paddr <= win_addr;
               Pwdata <= win_wdata;
               Pwrite <= req_write[win];
            end
         end else if (state == SETUP) begin
            state <= ACCESS;
            Penable <= 1'b1;
         end else if (state == ERR) begin
            state <= IDLE;
            done <= own;
            err <= 1'b1;
         end else if (fin) begin
            state <= IDLE;
            Pselx <= '0;
            Penable <= 1'b0;
         end
      end
   end
endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- APB master-side controller: shares one APB bus between NUM_REQ local requesters.
- Round-robin arbitration; runs the APB SETUP/ACCESS sequence; decodes the address into the 4-bit Pselx slave select.
- Returns read data, completion and error status to the winning requester.
- Drives the same Paddr/Pwdata/Pwrite/Penable/Pselx/Prdata bus the bridge's APB side uses.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- BASE_NIBBLE, 4'h8, required Paddr[31:28] for a legal APB access.

Ports:
- clk  input  1  bus clock; all logic on posedge.
- Hresetn  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-requester transfer request; held with its payload until its done.
- req_write  input  NUM_REQ  1 = write, 0 = read.
- req_addr  input  NUM_REQ*32  flattened addresses; slice i = requester i.
- req_wdata  input  NUM_REQ*32  flattened write data.
- gnt  output  NUM_REQ  one-hot, one-cycle pulse: request accepted.
- done  output  NUM_REQ  one-hot, one-cycle pulse: transfer finished.
- err  output  1  valid with done: 1 = address decode error.
- rdata  output  32  valid with done for reads.
- Paddr  output  32  APB address.
- Pwdata  output  32  APB write data.
- Pwrite  output  1  APB direction.
- Pselx  output  4  one-hot APB slave select.
- Penable  output  1  APB enable.
- Prdata  input  32  APB read data.

Behaviour:
- Reset (Hresetn low, asynchronous, effective immediately):
  - state IDLE; rr pointer 0 (req[0] highest priority).
  - Paddr, Pwdata, rdata = 0; Pwrite, Penable, Pselx, gnt, done, err = 0.
  - Reset mid-transfer aborts it with no done pulse.
- States: IDLE, SETUP, ACCESS, ERR.
- Arbitration: evaluated in IDLE and on the ACCESS-completion edge.
  - Winner = first requesting index at or after rr pointer, wrapping modulo NUM_REQ.
  - After a grant, the pointer moves to winner+1 (mod NUM_REQ).
  - The current owner is masked from arbitration on its completion edge and during its done cycle, so a held req is never re-granted twice.
- Decode: legal iff req_addr[31:28] == BASE_NIBBLE; slave = addr[27:26]; Pselx = 1 << slave.
- IDLE:
  - No requester: stay in IDLE; Pselx = 0, Penable = 0; Paddr/Pwdata/Pwrite hold their last values.
  - Winner with legal address: go to SETUP; register Paddr/Pwdata/Pwrite/Pselx; gnt[winner] = 1 during the SETUP cycle.
  - Winner with illegal address: go to ERR; gnt[winner] = 1; Pselx stays 0.
- SETUP: Penable = 0, Pselx valid; always goes to ACCESS next cycle.
- ACCESS: Penable = 1; Paddr/Pwdata/Pwrite/Pselx stable. Completes after 1 cycle (see optional feature). On the completion edge:
  - Capture Prdata into rdata (reads only; writes leave rdata unchanged).
  - Register done[owner] = 1, err = 0 for the next cycle.
  - If another unmasked req is pending: go straight to SETUP with the new payload (back-to-back, no IDLE cycle). Otherwise go to IDLE with Pselx = 0, Penable = 0.
- ERR: one cycle, then IDLE. The following cycle shows done[owner] = 1, err = 1; no APB activity.
- Latency: req sampled at edge E0 → SETUP after E0 → ACCESS after E1 → done high in the cycle after E2 (3 cycles, zero-wait slave).
- gnt, done and err are never asserted outside their single pulse cycle.
- Behaviour is undefined if a requester changes its payload between gnt and done.

Optional Feature:
- Macro APB_PREADY_EN.
- Defined: adds port Pready (input, 1). ACCESS completes only on an edge where Pready = 1; while Pready = 0, Penable and all address/data/control outputs hold.
- Undefined: no Pready port; ACCESS always lasts exactly one cycle.

Test Plan:
- req[0] write, addr 0x8000_0010, wdata 0xDEADBEEF → SETUP: Pselx = 0001, Penable = 0; ACCESS: Penable = 1, Pwrite = 1, Pwdata = 0xDEADBEEF; done[0] = 1 with err = 0 three cycles after request.
- req[1] read, addr 0x8800_0004, Prdata = 0x12345678 in ACCESS → Pselx = 0100, Pwrite = 0; rdata = 0x12345678 with done[1].
- req[0] and req[1] held continuously after reset, each re-asserted after its done → grants alternate 0,1,0,1; ACCESS→SETUP back-to-back with no IDLE between owners.
- req[0] addr 0x9000_0000 → gnt[0], Pselx stays 0, Penable never 1; done[0] = 1 and err = 1 two cycles after request.
- Hresetn low during ACCESS → Pselx, Penable, gnt, done = 0 immediately, no done pulse; after release, new req[1] served normally starting from pointer 0.
- With APB_PREADY_EN, Pready low for 3 ACCESS cycles → Penable high for 4 cycles with Paddr stable; done one cycle after Pready = 1.
